fifo_slot_tracker: RTL and testbench

- Parametrised circular FIFO with per-slot occupancy tracking. Stores WIDTH-bit entries in DEPTH slots.
- Exports a registered per-slot fullness vector alongside count, full/empty and sticky error flags.
- Sits beside push/pop producers in the datapath. Downstream arbitration and debug logic read slot occupancy directly instead of re-decoding pointers.

---
 rtl/fifo_slot_tracker_if.sv | 28 ++
 rtl/fifo_slot_tracker.sv | 79 +++++++
 tb/tb_fifo_slot_tracker.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_slot_tracker_if.sv
// rtl/fifo_slot_tracker_if.sv - push/pop handshake and status bundle for fifo_slot_tracker
interface fifo_slot_tracker_if #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2,
  parameter int WIDTH      = 8
);
  logic                  fifo_push;
  logic [WIDTH-1:0]      push_data;
  logic                  fifo_pop;
  logic                  clear_err;
  logic [WIDTH-1:0]      pop_data;
  logic [DEPTH-1:0]      fullness;
  logic [DEPTH_BITS:0]   count;
  logic                  full;
  logic                  empty;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output fifo_push, push_data, fifo_pop, clear_err,
    input  pop_data, fullness, count, full, empty, overflow, underflow
  );

  modport slave (
    input  fifo_push, push_data, fifo_pop, clear_err,
    output pop_data, fullness, count, full, empty, overflow, underflow
  );
endinterface

// File: rtl/fifo_slot_tracker.sv
// rtl/fifo_slot_tracker.sv - circular FWFT FIFO exporting registered per-slot occupancy
module fifo_slot_tracker #(
  parameter int DEPTH      = 4,
  parameter int DEPTH_BITS = 2,
  parameter int WIDTH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  fifo_slot_tracker_if.slave bus
);
  localparam logic [DEPTH_BITS-1:0] LAST_SLOT  = DEPTH_BITS'(DEPTH - 1);
  localparam logic [DEPTH_BITS:0]   FULL_COUNT = (DEPTH_BITS + 1)'(DEPTH);

  logic [WIDTH-1:0]      mem [DEPTH];
  logic [DEPTH_BITS-1:0] wr_ptr;
  logic [DEPTH_BITS-1:0] rd_ptr;
  logic [DEPTH_BITS:0]   count_q;
  logic [DEPTH-1:0]      fullness_q;
  logic [DEPTH-1:0]      fullness_next;
  logic                  overflow_q;
  logic                  underflow_q;
  logic                  full_w;
  logic                  empty_w;
  logic                  push_ok;
  logic                  pop_ok;

  // Explicit wrap compare keeps non-power-of-two depths correct.
  function automatic logic [DEPTH_BITS-1:0] next_ptr(input logic [DEPTH_BITS-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  assign full_w  = (count_q == FULL_COUNT);
  assign empty_w = (count_q == '0);
  assign push_ok = bus.fifo_push & (~full_w | bus.fifo_pop);
  assign pop_ok  = bus.fifo_pop & ~empty_w;

  // Push is applied after pop so a same-slot collision while full keeps the bit set.
  always_comb begin
    fullness_next = fullness_q;
    if (pop_ok)  fullness_next[rd_ptr] = 1'b0;
    if (push_ok) fullness_next[wr_ptr] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_q     <= '0;
      fullness_q  <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= next_ptr(wr_ptr);
      if (pop_ok)  rd_ptr <= next_ptr(rd_ptr);
      if (push_ok && !pop_ok)      count_q <= count_q + 1'b1;
      else if (pop_ok && !push_ok) count_q <= count_q - 1'b1;
      fullness_q  <= fullness_next;
      overflow_q  <= (overflow_q & ~bus.clear_err) | (bus.fifo_push & full_w & ~bus.fifo_pop);
      underflow_q <= (underflow_q & ~bus.clear_err) | (bus.fifo_pop & empty_w);
    end
  end

  // Storage is deliberately left out of reset; stale contents are hidden by fullness.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem[wr_ptr] <= bus.push_data;
  end

  assign bus.pop_data  = mem[rd_ptr];
  assign bus.fullness  = fullness_q;
  assign bus.count     = count_q;
  assign bus.full      = full_w;
  assign bus.empty     = empty_w;
  assign bus.overflow  = overflow_q;
  assign bus.underflow = underflow_q;

  occupancy_matches_count : assert property (
    @(posedge clk) disable iff (rst) $countones(fullness_q) == int'(count_q)
  );
endmodule

// File: tb/tb_fifo_slot_tracker.sv
// tb/tb_fifo_slot_tracker.sv - directed self-checking bench for fifo_slot_tracker
module tb_fifo_slot_tracker;
  logic clk;
  logic rst4;
  logic rst3;
  int   n_cmp;
  int   n_bad;

  fifo_slot_tracker_if #(.DEPTH(4), .DEPTH_BITS(2), .WIDTH(8)) if4 ();
  fifo_slot_tracker_if #(.DEPTH(3), .DEPTH_BITS(2), .WIDTH(8)) if3 ();

  fifo_slot_tracker #(.DEPTH(4), .DEPTH_BITS(2), .WIDTH(8)) u_dut4 (
    .clk (clk),
    .rst (rst4),
    .bus (if4.slave)
  );

  fifo_slot_tracker #(.DEPTH(3), .DEPTH_BITS(2), .WIDTH(8)) u_dut3 (
    .clk (clk),
    .rst (rst3),
    .bus (if3.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive4(input logic p, input logic [7:0] d, input logic q, input logic c, input logic r);
    if4.fifo_push = p;
    if4.push_data = d;
    if4.fifo_pop  = q;
    if4.clear_err = c;
    rst4          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drive3(input logic p, input logic [7:0] d, input logic q, input logic c, input logic r);
    if3.fifo_push = p;
    if3.push_data = d;
    if3.fifo_pop  = q;
    if3.clear_err = c;
    rst3          = r;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.count !== 3'd0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", if4.count); end
    n_cmp++; if (if4.fullness !== 4'b0000) begin n_bad++; $display("FAIL reset_fullness: got %b want 0000", if4.fullness); end
    n_cmp++; if (if4.empty !== 1'b1) begin n_bad++; $display("FAIL reset_empty: got %b want 1", if4.empty); end
    n_cmp++; if (if4.full !== 1'b0) begin n_bad++; $display("FAIL reset_full: got %b want 0", if4.full); end
    n_cmp++; if ({if4.overflow, if4.underflow} !== 2'b00) begin n_bad++; $display("FAIL reset_flags: got %b want 00", {if4.overflow, if4.underflow}); end
  endtask

  task automatic test_push_sequence;
    if4.fifo_push = 1'b1;
    if4.push_data = 8'h11;
    #1;
    n_cmp++; if (if4.empty !== 1'b1) begin n_bad++; $display("FAIL empty_before_edge: got %b want 1", if4.empty); end
    drive4(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b0001) begin n_bad++; $display("FAIL push1_fullness: got %b want 0001", if4.fullness); end
    n_cmp++; if (if4.empty !== 1'b0) begin n_bad++; $display("FAIL push1_empty: got %b want 0", if4.empty); end
    n_cmp++; if (if4.pop_data !== 8'h11) begin n_bad++; $display("FAIL push1_head: got %h want 11", if4.pop_data); end
    drive4(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b0011) begin n_bad++; $display("FAIL push2_fullness: got %b want 0011", if4.fullness); end
    n_cmp++; if (if4.pop_data !== 8'h11) begin n_bad++; $display("FAIL push2_head: got %h want 11", if4.pop_data); end
    drive4(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b0111) begin n_bad++; $display("FAIL push3_fullness: got %b want 0111", if4.fullness); end
    n_cmp++; if (if4.count !== 3'd3) begin n_bad++; $display("FAIL push3_count: got %0d want 3", if4.count); end
    n_cmp++; if (if4.pop_data !== 8'h11) begin n_bad++; $display("FAIL push3_head: got %h want 11", if4.pop_data); end
    n_cmp++; if (if4.full !== 1'b0) begin n_bad++; $display("FAIL push3_full: got %b want 0", if4.full); end
  endtask

  task automatic test_overflow;
    drive4(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b1111) begin n_bad++; $display("FAIL fill_fullness: got %b want 1111", if4.fullness); end
    n_cmp++; if (if4.full !== 1'b1) begin n_bad++; $display("FAIL fill_full: got %b want 1", if4.full); end
    n_cmp++; if (if4.overflow !== 1'b0) begin n_bad++; $display("FAIL fill_overflow: got %b want 0", if4.overflow); end
    drive4(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", if4.overflow); end
    n_cmp++; if (if4.fullness !== 4'b1111) begin n_bad++; $display("FAIL ovf_fullness: got %b want 1111", if4.fullness); end
    n_cmp++; if (if4.count !== 3'd4) begin n_bad++; $display("FAIL ovf_count: got %0d want 4", if4.count); end
    n_cmp++; if (if4.pop_data !== 8'h11) begin n_bad++; $display("FAIL ovf_head: got %h want 11", if4.pop_data); end
    drive4(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (if4.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", if4.overflow); end
    drive4(1'b1, 8'h66, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (if4.overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_set_wins: got %b want 1", if4.overflow); end
    drive4(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (if4.overflow !== 1'b0) begin n_bad++; $display("FAIL ovf_clear2: got %b want 0", if4.overflow); end
  endtask

  task automatic test_full_push_pop;
    logic [7:0] exp_order [4];
    exp_order = '{8'h22, 8'h33, 8'h44, 8'hAA};
    drive4(1'b1, 8'hAA, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b1111) begin n_bad++; $display("FAIL fpp_fullness: got %b want 1111", if4.fullness); end
    n_cmp++; if (if4.count !== 3'd4) begin n_bad++; $display("FAIL fpp_count: got %0d want 4", if4.count); end
    n_cmp++; if (if4.pop_data !== 8'h22) begin n_bad++; $display("FAIL fpp_head: got %h want 22", if4.pop_data); end
    n_cmp++; if ({if4.overflow, if4.underflow} !== 2'b00) begin n_bad++; $display("FAIL fpp_flags: got %b want 00", {if4.overflow, if4.underflow}); end
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (if4.pop_data !== exp_order[i]) begin n_bad++; $display("FAIL drain_head[%0d]: got %h want %h", i, if4.pop_data, exp_order[i]); end
      drive4(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    end
    n_cmp++; if (if4.empty !== 1'b1) begin n_bad++; $display("FAIL drain_empty: got %b want 1", if4.empty); end
    n_cmp++; if (if4.fullness !== 4'b0000) begin n_bad++; $display("FAIL drain_fullness: got %b want 0000", if4.fullness); end
    drive4(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if4.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set: got %b want 1", if4.underflow); end
    n_cmp++; if (if4.count !== 3'd0) begin n_bad++; $display("FAIL udf_count: got %0d want 0", if4.count); end
    drive4(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (if4.underflow !== 1'b1) begin n_bad++; $display("FAIL udf_set_wins: got %b want 1", if4.underflow); end
    drive4(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (if4.underflow !== 1'b0) begin n_bad++; $display("FAIL udf_clear: got %b want 0", if4.underflow); end
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  // Pointers start at slot 1 here; two primed entries then six push/pop pairs.
  task automatic test_wrap;
    logic [3:0] exp_full [6];
    logic [7:0] exp_head [6];
    logic [7:0] d;
    exp_full = '{4'b1100, 4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};
    exp_head = '{8'hA1, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    drive4(1'b1, 8'hA0, 1'b0, 1'b0, 1'b0);
    drive4(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b0110) begin n_bad++; $display("FAIL wrap_prime: got %b want 0110", if4.fullness); end
    n_cmp++; if (if4.pop_data !== 8'hA0) begin n_bad++; $display("FAIL wrap_prime_head: got %h want a0", if4.pop_data); end
    for (int k = 0; k < 6; k++) begin
      d = 8'hB0 + 8'(k);
      drive4(1'b1, d, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (if4.fullness !== exp_full[k]) begin n_bad++; $display("FAIL wrap_fullness[%0d]: got %b want %b", k, if4.fullness, exp_full[k]); end
      n_cmp++; if (if4.pop_data !== exp_head[k]) begin n_bad++; $display("FAIL wrap_head[%0d]: got %h want %h", k, if4.pop_data, exp_head[k]); end
    end
    n_cmp++; if (if4.count !== 3'd2) begin n_bad++; $display("FAIL wrap_count: got %0d want 2", if4.count); end
    drive4(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if4.pop_data !== 8'hB5) begin n_bad++; $display("FAIL wrap_tail: got %h want b5", if4.pop_data); end
    n_cmp++; if (if4.fullness !== 4'b0001) begin n_bad++; $display("FAIL wrap_tail_fullness: got %b want 0001", if4.fullness); end
    drive4(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if4.empty !== 1'b1) begin n_bad++; $display("FAIL wrap_empty: got %b want 1", if4.empty); end
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_empty_push_pop;
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive4(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if4.underflow !== 1'b1) begin n_bad++; $display("FAIL epp_underflow: got %b want 1", if4.underflow); end
    n_cmp++; if (if4.count !== 3'd1) begin n_bad++; $display("FAIL epp_count: got %0d want 1", if4.count); end
    n_cmp++; if (if4.fullness !== 4'b0001) begin n_bad++; $display("FAIL epp_fullness: got %b want 0001", if4.fullness); end
    n_cmp++; if (if4.pop_data !== 8'h77) begin n_bad++; $display("FAIL epp_head: got %h want 77", if4.pop_data); end
  endtask

  task automatic test_reset_midstream;
    drive4(1'b1, 8'h88, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.count !== 3'd2) begin n_bad++; $display("FAIL mid_pre_count: got %0d want 2", if4.count); end
    n_cmp++; if (if4.underflow !== 1'b1) begin n_bad++; $display("FAIL mid_pre_underflow: got %b want 1", if4.underflow); end
    drive4(1'b1, 8'h99, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (if4.count !== 3'd0) begin n_bad++; $display("FAIL mid_count: got %0d want 0", if4.count); end
    n_cmp++; if (if4.fullness !== 4'b0000) begin n_bad++; $display("FAIL mid_fullness: got %b want 0000", if4.fullness); end
    n_cmp++; if (if4.empty !== 1'b1) begin n_bad++; $display("FAIL mid_empty: got %b want 1", if4.empty); end
    n_cmp++; if ({if4.overflow, if4.underflow} !== 2'b00) begin n_bad++; $display("FAIL mid_flags: got %b want 00", {if4.overflow, if4.underflow}); end
    drive4(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if4.fullness !== 4'b0001) begin n_bad++; $display("FAIL mid_repush_fullness: got %b want 0001", if4.fullness); end
    n_cmp++; if (if4.pop_data !== 8'h5A) begin n_bad++; $display("FAIL mid_repush_head: got %h want 5a", if4.pop_data); end
    drive4(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic test_depth3;
    drive3(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    drive3(1'b1, 8'hC0, 1'b0, 1'b0, 1'b0);
    drive3(1'b1, 8'hC1, 1'b0, 1'b0, 1'b0);
    drive3(1'b1, 8'hC2, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if3.fullness !== 3'b111) begin n_bad++; $display("FAIL d3_fill_fullness: got %b want 111", if3.fullness); end
    n_cmp++; if (if3.full !== 1'b1) begin n_bad++; $display("FAIL d3_full: got %b want 1", if3.full); end
    n_cmp++; if (if3.count !== 3'd3) begin n_bad++; $display("FAIL d3_count: got %0d want 3", if3.count); end
    drive3(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if3.fullness !== 3'b111) begin n_bad++; $display("FAIL d3_pp_fullness: got %b want 111", if3.fullness); end
    n_cmp++; if (if3.pop_data !== 8'hC1) begin n_bad++; $display("FAIL d3_pp_head: got %h want c1", if3.pop_data); end
    drive3(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if3.pop_data !== 8'hC2) begin n_bad++; $display("FAIL d3_pop1_head: got %h want c2", if3.pop_data); end
    n_cmp++; if (if3.fullness !== 3'b101) begin n_bad++; $display("FAIL d3_pop1_fullness: got %b want 101", if3.fullness); end
    drive3(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    n_cmp++; if (if3.pop_data !== 8'hC3) begin n_bad++; $display("FAIL d3_wrap_head: got %h want c3", if3.pop_data); end
    n_cmp++; if (if3.fullness !== 3'b001) begin n_bad++; $display("FAIL d3_wrap_fullness: got %b want 001", if3.fullness); end
    drive3(1'b1, 8'hC4, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if3.fullness !== 3'b011) begin n_bad++; $display("FAIL d3_c4_fullness: got %b want 011", if3.fullness); end
    n_cmp++; if (if3.count !== 3'd2) begin n_bad++; $display("FAIL d3_c4_count: got %0d want 2", if3.count); end
    drive3(1'b1, 8'hEE, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (if3.count !== 3'd0) begin n_bad++; $display("FAIL d3_rst_count: got %0d want 0", if3.count); end
    n_cmp++; if (if3.fullness !== 3'b000) begin n_bad++; $display("FAIL d3_rst_fullness: got %b want 000", if3.fullness); end
    n_cmp++; if (if3.empty !== 1'b1) begin n_bad++; $display("FAIL d3_rst_empty: got %b want 1", if3.empty); end
    drive3(1'b1, 8'hD0, 1'b0, 1'b0, 1'b0);
    n_cmp++; if (if3.fullness !== 3'b001) begin n_bad++; $display("FAIL d3_repush_fullness: got %b want 001", if3.fullness); end
    n_cmp++; if (if3.pop_data !== 8'hD0) begin n_bad++; $display("FAIL d3_repush_head: got %h want d0", if3.pop_data); end
    drive3(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst4 = 1'b1;
    rst3 = 1'b1;
    if4.fifo_push = 1'b0; if4.push_data = 8'h00; if4.fifo_pop = 1'b0; if4.clear_err = 1'b0;
    if3.fifo_push = 1'b0; if3.push_data = 8'h00; if3.fifo_pop = 1'b0; if3.clear_err = 1'b0;
    test_reset;
    test_push_sequence;
    test_overflow;
    test_full_push_pop;
    test_wrap;
    test_empty_push_pop;
    test_reset_midstream;
    test_depth3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
